// File: rtl/ldpc_pkg.sv
// Shared state encoding, status codes and parameter defaults for the LDPC
// iteration controller and its LLR buffer.
package ldpc_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_R      = 24;
    localparam int DEF_D      = 24;
    localparam int DEF_ITER_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] ST_CONV  = 2'b01;
    localparam logic [1:0] ST_LIMIT = 2'b10;

endpackage

// File: rtl/ldpc_llr_buf.sv
// Channel-LLR storage for the active frame; with LDPC_PINGPONG_EN a second
// (spare) buffer takes the next frame while the active one is decoded.
module ldpc_llr_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_act_i,
    input  logic         wr_spare_i,
    input  logic         swap_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] act_o,
    output logic         spare_full_o
);

`ifdef LDPC_PINGPONG_EN
    logic [W-1:0] mem_q [2];
    logic         sel_q;
    logic         full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            sel_q    <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            if (wr_act_i)   mem_q[sel_q]  <= data_i;
            if (wr_spare_i) mem_q[~sel_q] <= data_i;
            if (swap_i)     sel_q         <= ~sel_q;
            // A spare written in the swap cycle becomes active at once, so it is not left full.
            full_q <= (full_q | wr_spare_i) & ~swap_i;
        end
    end

    assign act_o        = mem_q[sel_q];
    assign spare_full_o = full_q;
`else
    logic [W-1:0] mem_q;
    logic         unused_ok;

    assign unused_ok = wr_spare_i ^ swap_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (wr_act_i) begin
            mem_q <= data_i;
        end
    end

    assign act_o        = mem_q;
    assign spare_full_o = 1'b0;
`endif

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// LDPC decoder iteration controller: loads a frame, runs CNU/VNU iterations
// until syndrome-zero or the iteration limit, then holds the result.
// Optional double buffering of input frames: LDPC_PINGPONG_EN.
module ldpc_iter_ctrl
    import ldpc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int R      = DEF_R,
    parameter int D      = DEF_D,
    parameter int ITER_W = DEF_ITER_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [R*D*DATA_W-1:0] in_llr,
    input  logic [ITER_W-1:0]     max_iter,
    output logic                  arr_clr,
    output logic                  arr_en,
    output logic [R*D*DATA_W-1:0] arr_llr,
    input  logic [R*D-1:0]        dec_in,
    input  logic                  syn_ok,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [R*D-1:0]        out_dec,
    output logic [ITER_W-1:0]     out_iters,
    output logic [1:0]            out_status,
    output state_t                dbg_state_o
);

    localparam int N = R * D;

    state_t              state_q, state_d;
    logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d, cnt_inc;
    logic [ITER_W-1:0]   lim_q, lim_d, lim_in;
    logic [ITER_W-1:0]   iters_q, iters_d;
    logic [N-1:0]        dec_q, dec_d;
    logic [1:0]          status_q, status_d;
    logic                rdy_q;
    logic                accept, wr_act, wr_spare, swap, spare_full;
`ifdef LDPC_PINGPONG_EN
    logic [ITER_W-1:0]   lim_sp_q, lim_sp_d;
`endif

    // A max_iter of zero still runs one iteration.
    assign lim_in  = (max_iter == '0) ? ITER_W'(1) : max_iter;
    // cnt_inc counts the iteration being performed in this ITER cycle.
    assign cnt_inc = (iter_cnt_q == '1) ? iter_cnt_q : iter_cnt_q + ITER_W'(1);

`ifdef LDPC_PINGPONG_EN
    assign in_ready = rdy_q & ~spare_full;
`else
    assign in_ready = rdy_q & (state_q == S_IDLE) & ~spare_full;
`endif
    assign accept = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        lim_d      = lim_q;
        iters_d    = iters_q;
        dec_d      = dec_q;
        status_d   = status_q;
        arr_clr    = 1'b0;
        arr_en     = 1'b0;
        wr_act     = 1'b0;
        wr_spare   = 1'b0;
        swap       = 1'b0;
`ifdef LDPC_PINGPONG_EN
        lim_sp_d   = lim_sp_q;
        if (accept && state_q != S_IDLE) begin
            wr_spare = 1'b1;
            lim_sp_d = lim_in;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_act  = 1'b1;
                    lim_d   = lim_in;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                arr_clr    = 1'b1;
                iter_cnt_d = '0;
                state_d    = S_ITER;
            end
            S_ITER: begin
                arr_en     = 1'b1;
                iter_cnt_d = cnt_inc;
                if (syn_ok || cnt_inc == lim_q) begin
                    status_d = syn_ok ? ST_CONV : ST_LIMIT;
                    dec_d    = dec_in;
                    iters_d  = cnt_inc;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
`ifdef LDPC_PINGPONG_EN
                    if (spare_full || wr_spare) begin
                        swap    = 1'b1;
                        lim_d   = wr_spare ? lim_in : lim_sp_q;
                        state_d = S_LOAD;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            iter_cnt_q <= '0;
            lim_q      <= '0;
            iters_q    <= '0;
            dec_q      <= '0;
            status_q   <= '0;
            rdy_q      <= 1'b0;
`ifdef LDPC_PINGPONG_EN
            lim_sp_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            lim_q      <= lim_d;
            iters_q    <= iters_d;
            dec_q      <= dec_d;
            status_q   <= status_d;
            rdy_q      <= 1'b1;
`ifdef LDPC_PINGPONG_EN
            lim_sp_q   <= lim_sp_d;
`endif
        end
    end

    ldpc_llr_buf #(
        .W (N * DATA_W)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_act_i     (wr_act),
        .wr_spare_i   (wr_spare),
        .swap_i       (swap),
        .data_i       (in_llr),
        .act_o        (arr_llr),
        .spare_full_o (spare_full)
    );

    assign out_valid   = (state_q == S_DONE);
    assign out_dec     = dec_q;
    assign out_iters   = iters_q;
    assign out_status  = status_q;
    assign dbg_state_o = state_q;

endmodule
